// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block-width constants and ShiftRows index helpers
package aes_pkg;

   localparam int NB_AES128 = 4;
   localparam int NB_R192   = 6;
   localparam int NB_R256   = 8;

   // Rijndael row rotation; only 8-column blocks use the wider offsets on rows 2 and 3
   function automatic int shift_off(input int nb, input int row);
      if (nb == NB_R256 && row >= 2) begin
         return row + 1;
      end
      return row;
   endfunction

   // Lowest-numbered bit of byte (row, col) in the column-major ascending state vector
   function automatic int byte_lsb(input int row, input int col);
      return 32 * col + 8 * row;
   endfunction

   function automatic bit nb_legal(input int nb);
      return (nb == NB_AES128) || (nb == NB_R192) || (nb == NB_R256);
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational forward/inverse ShiftRows byte routing
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [0:32*NB-1] i_state,
   input  logic             i_inv,
   output logic [0:32*NB-1] o_state
);

   // Every output byte is a 2:1 mux between its forward and inverse source byte in the same row
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int FWD_SRC = (c + shift_off(NB, r)) % NB;
         localparam int INV_SRC = (c - shift_off(NB, r) + NB) % NB;
         assign o_state[byte_lsb(r, c) +: 8] = i_inv ? i_state[byte_lsb(r, INV_SRC) +: 8]
                                                     : i_state[byte_lsb(r, FWD_SRC) +: 8];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - elastic ShiftRows/InvShiftRows stage with valid/ready and tag
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB     = 4,
   parameter int STAGES = 1,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [0:32*NB-1]  in_state,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:32*NB-1]  out_state,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
      $error("shift_rows_pipe: STAGES must be 1 or 2");
   end

   // Index k carries what stage k presents downstream; index 0 is the permuted upstream input.
   // w_ready[k] is the ready seen by whatever sits at index k.
   logic [STAGES:0]   w_valid;
   logic [STAGES:0]   w_ready;
   logic [0:32*NB-1]  w_state [0:STAGES];
   logic [TAG_W-1:0]  w_tag   [0:STAGES];
   logic [0:32*NB-1]  w_perm;

   shift_rows_perm #(
      .NB (NB)
   ) u_perm (
      .i_state (in_state),
      .i_inv   (in_inv),
      .o_state (w_perm)
   );

   assign w_valid[0]      = in_valid;
   assign w_state[0]      = w_perm;
   assign w_tag[0]        = in_tag;
   assign w_ready[STAGES] = out_ready;

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      logic              r_valid;
      logic [0:32*NB-1]  r_state;
      logic [TAG_W-1:0]  r_tag;

      // A slice can take new data when empty or when its current word leaves this cycle
      assign w_ready[k-1] = !r_valid || w_ready[k];
      assign w_valid[k]   = r_valid;
      assign w_state[k]   = r_state;
      assign w_tag[k]     = r_tag;

      // Elastic slice: valid follows upstream whenever open; data loads only on an accepted transfer
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_state <= '0;
            r_tag   <= '0;
         end else begin
            if (w_ready[k-1]) begin
               r_valid <= w_valid[k-1];
            end
            if (w_ready[k-1] && w_valid[k-1]) begin
               r_state <= w_state[k-1];
               r_tag   <= w_tag[k-1];
            end
         end
      end
   end

   assign in_ready  = w_ready[0];
   assign out_valid = w_valid[STAGES];
   assign out_state = w_state[STAGES];
   assign out_tag   = w_tag[STAGES];
   assign busy      = |w_valid[STAGES:1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - self-checking bench for shift_rows_pipe
module tb_shift_rows_pipe;

   typedef logic [0:255] st_t;
   typedef struct {
      st_t        st;
      logic [3:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // a_*: NB=4, two stages
   logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
   logic [3:0]   a_in_tag, a_out_tag;
   logic [0:127] a_in_state, a_out_state;

   // b_*: NB=8, one stage
   logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
   logic [3:0]   b_in_tag, b_out_tag;
   logic [0:255] b_in_state, b_out_state;

   shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
      .in_tag(a_in_tag), .in_state(a_in_state),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_state(a_out_state), .out_tag(a_out_tag), .busy(a_busy)
   );

   shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
      .in_tag(b_in_tag), .in_state(b_in_state),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_state(b_out_state), .out_tag(b_out_tag), .busy(b_busy)
   );

   // Reference: byte matrix rotation straight from the Rijndael row-offset table
   function automatic st_t ref_shift(input int nb, input st_t s, input bit inv);
      int   off [4];
      int   src;
      st_t  o;
      o = '0;
      off[0] = 0;
      off[1] = 1;
      off[2] = (nb == 8) ? 3 : 2;
      off[3] = (nb == 8) ? 4 : 3;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < nb; c++) begin
            src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
            o[32*c+8*r +: 8] = s[32*src+8*r +: 8];
         end
      end
      return o;
   endfunction

   function automatic st_t rand_st();
      st_t s;
      for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic test_reset();
      a_in_valid = 0; a_in_inv = 0; a_in_tag = '0; a_in_state = '0; a_out_ready = 0;
      b_in_valid = 0; b_in_inv = 0; b_in_tag = '0; b_in_state = '0; b_out_ready = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
      n_checks++; if (a_out_state !== 128'h0) begin n_fail++; $display("FAIL reset_a_out_state: got %h want 0", a_out_state); end
      n_checks++; if (a_out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_a_out_tag: got %h want 0", a_out_tag); end
      n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
      n_checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid_busy: got %b/%b want 0/0", b_out_valid, b_busy); end
      n_checks++; if (b_out_state !== 256'h0 || b_out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_b_out: got %h/%h want 0/0", b_out_state, b_out_tag); end
   endtask

   task automatic test_fips();
      int lat;
      @(posedge clk); #1;
      a_out_ready = 1; a_in_valid = 1; a_in_inv = 0; a_in_tag = 4'h5;
      a_in_state = 128'hd42711aee0bf98f1b8b45de51e415230;
      @(posedge clk); #1 a_in_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!a_out_valid && lat < 10) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL fips_fwd_latency: got %0d want 2", lat); end
      n_checks++; if (a_out_state !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin n_fail++; $display("FAIL fips_fwd_state: got %h want d4bf5d30e0b452aeb84111f11e2798e5", a_out_state); end
      n_checks++; if (a_out_tag !== 4'h5) begin n_fail++; $display("FAIL fips_fwd_tag: got %h want 5", a_out_tag); end

      @(posedge clk); #1;
      a_in_valid = 1; a_in_inv = 1; a_in_tag = 4'ha;
      a_in_state = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      @(posedge clk); #1 a_in_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!a_out_valid && lat < 10) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL fips_inv_latency: got %0d want 2", lat); end
      n_checks++; if (a_out_state !== 128'hd42711aee0bf98f1b8b45de51e415230) begin n_fail++; $display("FAIL fips_inv_state: got %h want d42711aee0bf98f1b8b45de51e415230", a_out_state); end
      n_checks++; if (a_out_tag !== 4'ha) begin n_fail++; $display("FAIL fips_inv_tag: got %h want a", a_out_tag); end
      @(posedge clk); #1;
   endtask

   task automatic test_nb8_pattern();
      st_t s, e;
      int  lat;
      s = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++) s[32*c+8*r +: 8] = 8'(16*r + c);
      e = ref_shift(8, s, 1'b0);
      @(posedge clk); #1;
      b_out_ready = 1; b_in_valid = 1; b_in_inv = 0; b_in_tag = 4'h9; b_in_state = s;
      @(posedge clk); #1 b_in_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!b_out_valid && lat < 10) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL nb8_latency: got %0d want 1", lat); end
      n_checks++; if (b_out_state[24 +: 8] !== 8'h34) begin n_fail++; $display("FAIL nb8_r3c0: got %h want 34", b_out_state[24 +: 8]); end
      n_checks++; if (b_out_state[16 +: 8] !== 8'h23) begin n_fail++; $display("FAIL nb8_r2c0: got %h want 23", b_out_state[16 +: 8]); end
      n_checks++; if (b_out_state[232 +: 8] !== 8'h10) begin n_fail++; $display("FAIL nb8_r1c7: got %h want 10", b_out_state[232 +: 8]); end
      n_checks++; if (b_out_state !== e || b_out_tag !== 4'h9) begin n_fail++; $display("FAIL nb8_full: got %h/%h want %h/9", b_out_state, b_out_tag, e); end
      @(posedge clk); #1;
   endtask

   // 16 transfers with both sides always willing, inverse mode alternating every cycle
   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e;
      st_t  s, m;
      int   sent = 0, got = 0, cyc = 0, first_out = -1, last_out = -1;
      a_out_ready = 1;
      while (got < 16 && cyc < 100) begin
         @(posedge clk); #1;
         a_in_valid = (sent < 16);
         s = rand_st();
         a_in_state = s[0:127]; a_in_inv = sent[0]; a_in_tag = 4'(sent);
         @(negedge clk);
         if (a_in_valid) begin
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b want 1", cyc, a_in_ready); end
         end
         if (a_out_valid && a_out_ready) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL b2b_spurious: got tag %h want no output", a_out_tag); end
            else begin
               e = q.pop_front();
               m = e.st;
               if (a_out_state !== m[0:127] || a_out_tag !== e.tag) begin n_fail++; $display("FAIL b2b_data: got %h/%h want %h/%h", a_out_state, a_out_tag, m[0:127], e.tag); end
            end
            got++;
         end
         if (a_in_valid && a_in_ready) begin
            e.st = ref_shift(4, s, a_in_inv); e.tag = a_in_tag;
            q.push_back(e);
            sent++;
         end
         cyc++;
      end
      a_in_valid = 0;
      n_checks++; if (got !== 16 || last_out - first_out !== 15) begin n_fail++; $display("FAIL b2b_throughput: got %0d outputs over %0d cycles want 16 over 16", got, last_out - first_out + 1); end
   endtask

   // Tags 0..9 against a random out_ready pattern on the two-stage instance
   task automatic test_backpressure();
      exp_t         q[$];
      exp_t         e;
      st_t          s, m;
      int           sent = 0, got = 0, cyc = 0, infl;
      bit           prev_stall = 0;
      logic [0:127] prev_st;
      logic [3:0]   prev_tag;
      while (got < 10 && cyc < 300) begin
         @(posedge clk); #1;
         a_in_valid = (sent < 10);
         s = rand_st();
         a_in_state = s[0:127]; a_in_inv = 1'($urandom_range(0, 1)); a_in_tag = 4'(sent);
         a_out_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
         @(negedge clk);
         infl = q.size();
         n_checks++; if (a_in_ready !== !(infl == 2 && !a_out_ready)) begin n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b want %b (in flight %0d)", cyc, a_in_ready, !(infl == 2 && !a_out_ready), infl); end
         if (prev_stall) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_state !== prev_st || a_out_tag !== prev_tag) begin n_fail++; $display("FAIL bp_hold cyc %0d: got %b/%h/%h want 1/%h/%h", cyc, a_out_valid, a_out_state, a_out_tag, prev_st, prev_tag); end
         end
         prev_stall = a_out_valid && !a_out_ready;
         prev_st = a_out_state; prev_tag = a_out_tag;
         if (a_out_valid && a_out_ready) begin
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL bp_spurious: got tag %h want no output", a_out_tag); end
            else begin
               e = q.pop_front();
               m = e.st;
               if (a_out_state !== m[0:127] || a_out_tag !== e.tag) begin n_fail++; $display("FAIL bp_data: got %h/%h want %h/%h", a_out_state, a_out_tag, m[0:127], e.tag); end
            end
            got++;
         end
         if (a_in_valid && a_in_ready) begin
            e.st = ref_shift(4, s, a_in_inv); e.tag = a_in_tag;
            q.push_back(e);
            sent++;
         end
         cyc++;
      end
      a_in_valid = 0; a_out_ready = 1;
      n_checks++; if (got !== 10 || q.size() !== 0) begin n_fail++; $display("FAIL bp_count: got %0d delivered %0d pending want 10/0", got, q.size()); end
   endtask

   // Random valid, ready and mode on the NB=8 single-stage instance
   task automatic test_random_nb8();
      exp_t q[$];
      exp_t e;
      st_t  s;
      int   sent = 0, got = 0, cyc = 0, infl;
      while (got < 24 && cyc < 400) begin
         @(posedge clk); #1;
         b_in_valid = (sent < 24) && ($urandom_range(0, 9) < 7);
         s = rand_st();
         b_in_state = s; b_in_inv = 1'($urandom_range(0, 1)); b_in_tag = 4'($urandom);
         b_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         infl = q.size();
         n_checks++; if (b_in_ready !== !(infl == 1 && !b_out_ready)) begin n_fail++; $display("FAIL rnd8_in_ready cyc %0d: got %b want %b", cyc, b_in_ready, !(infl == 1 && !b_out_ready)); end
         if (b_out_valid && b_out_ready) begin
            n_checks++;
            if (q.size() == 0) begin n_fail++; $display("FAIL rnd8_spurious: got tag %h want no output", b_out_tag); end
            else begin
               e = q.pop_front();
               if (b_out_state !== e.st || b_out_tag !== e.tag) begin n_fail++; $display("FAIL rnd8_data: got %h/%h want %h/%h", b_out_state, b_out_tag, e.st, e.tag); end
            end
            got++;
         end
         if (b_in_valid && b_in_ready) begin
            e.st = ref_shift(8, s, b_in_inv); e.tag = b_in_tag;
            q.push_back(e);
            sent++;
         end
         cyc++;
      end
      b_in_valid = 0; b_out_ready = 1;
      n_checks++; if (got !== 24) begin n_fail++; $display("FAIL rnd8_count: got %0d want 24", got); end
   endtask

   task automatic test_reset_midflight();
      st_t s1, s2, s3, e;
      int  lat;
      s1 = rand_st(); s2 = rand_st(); s3 = rand_st();
      @(posedge clk); #1;
      a_out_ready = 0; a_in_valid = 1; a_in_inv = 0; a_in_tag = 4'h1; a_in_state = s1[0:127];
      @(posedge clk); #1;
      a_in_tag = 4'h2; a_in_state = s2[0:127];
      @(posedge clk); #1;
      a_in_valid = 0;
      n_checks++; if (a_busy !== 1'b1 || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got busy %b valid %b ready %b want 1/1/0", a_busy, a_out_valid, a_in_ready); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: got valid %b busy %b want 0/0", a_out_valid, a_busy); end
      n_checks++; if (a_out_state !== 128'h0 || a_out_tag !== 4'h0) begin n_fail++; $display("FAIL mid_async_clear: got %h/%h want 0/0", a_out_state, a_out_tag); end
      @(negedge clk); #1 rst = 1'b0;
      a_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc %0d: got out_valid %b tag %h want 0", i, a_out_valid, a_out_tag); end
      end
      @(posedge clk); #1;
      a_in_valid = 1; a_in_inv = 1; a_in_tag = 4'h7; a_in_state = s3[0:127];
      e = ref_shift(4, s3, 1'b1);
      @(posedge clk); #1 a_in_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!a_out_valid && lat < 10) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== 2 || a_out_state !== e[0:127] || a_out_tag !== 4'h7) begin n_fail++; $display("FAIL mid_recover: got lat %0d %h/%h want 2 %h/7", lat, a_out_state, a_out_tag, e[0:127]); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_fips();
      test_nb8_pattern();
      test_back_to_back();
      test_backpressure();
      test_random_nb8();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, handshaked successor to the combinational ShiftRows stage of the AES datapath.
- Supports Rijndael block widths of Nb = 4, 6 or 8 columns.
- Runtime mode selects forward ShiftRows (encrypt) or InvShiftRows (decrypt).
- Sits between SubBytes and MixColumns in the round pipeline. Provides 1 or 2 elastic register stages with valid/ready backpressure and a sideband tag.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8. Any other value is an elaboration error.
- STAGES, 1, number of elastic register stages; legal values 1 or 2.
- TAG_W, 4, width of the opaque sideband tag carried alongside the state.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a state.
- in_ready  output  1  block can accept this cycle.
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the data.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- in_state  input  32*NB  column-major state, bit order [0:32*NB-1]; byte (r,c) = bits [32*c+8*r +: 8].
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_state  output  32*NB  shifted state, same byte layout.
- out_tag  output  TAG_W  tag of the transfer on out_state.
- busy  output  1  any stage holds valid data.

Behaviour:
- Shift offsets per row r = 0..3:
  - NB = 4 or 6: {0,1,2,3}.
  - NB = 8: {0,1,3,4}.
- Forward: out(r,c) = in(r, (c + off[r]) mod NB).
- Inverse: out(r,c) = in(r, (c - off[r] + NB) mod NB).
- Row 0 is never moved. Permutation is pure byte routing with no arithmetic.
- The permutation is applied combinationally on entry to stage 1. in_inv selects per transfer, so mixed modes in flight are legal.
- Each stage holds a valid flag plus state/tag registers.
- Stage k loads when its upstream valid is 1 and (stage k empty, or stage k's downstream ready is 1).
  - in_ready = stage-1 load-enable condition excluding in_valid, i.e. stage 1 empty or draining this cycle.
  - Stage k drains when valid_k = 1 and its downstream ready is 1. Downstream of the last stage is out_ready.
  - Simultaneous drain and load in one cycle is legal and sustains full throughput.
- Throughput: 1 transfer/cycle when out_ready is held high.
- Latency: STAGES cycles from in_valid&&in_ready to out_valid.
- Stall: while out_valid=1 and out_ready=0, out_state and out_tag are held stable and the stage does not overwrite.
- With STAGES=2, in_ready deasserts only when both stages are full and out_ready=0.
  - in_ready depends combinationally on out_ready (no skid buffer). This is documented and accepted.
- Ordering: strictly FIFO; no reordering or dropping.
- Reset (asynchronous): all valid flags clear immediately.
  - out_valid=0, busy=0.
  - out_state and out_tag reset to all-zero.
  - in_ready reads 1 once rst deasserts.
  - Reset mid-transfer discards in-flight data; no partial output.
- busy = OR of all stage valid flags.
- in_inv and in_tag are don't-care when in_valid=0. Data registers may load only on accepted transfers.

Decomposition:
- Package aes_pkg holds:
  - Constants for legal NB values.
  - The shift-offset function shift_off(nb, row).
  - Byte-index helper byte_lsb(row, col) returning 32*col+8*row.
- Sub-module shift_rows_perm (combinational, parameter NB; inputs state and inv; output permuted state).
  - Reused by the key-schedule test model and by a future combined round unit.
- shift_rows_pipe instantiates shift_rows_perm once, then a generate loop of STAGES elastic register slices.

Test Plan:
- FIPS-197 vector, NB=4, inv=0: in_state=128'hd42711aee0bf98f1b8b45de51e415230 -> out_state=128'hd4bf5d30e0b452aeb84111f11e2798e5 after STAGES cycles; tag preserved.
- Same output vector fed back with inv=1 -> 128'hd42711aee0bf98f1b8b45de51e415230. Alternate inv every cycle; confirm each result matches its own mode.
- NB=8, byte (r,c) = 8'(16*r+c), inv=0 -> row3 byte at col0 equals 8'h34, row2 col0 equals 8'h23, row1 col7 equals 8'h10.
- Backpressure, STAGES=2: stream tags 0..9 with out_ready toggling in a pseudo-random pattern.
  - All 10 emerge in order with correct data.
  - Output is held stable during stalls.
  - in_ready=0 exactly when both stages are full and out_ready=0.
- Full throughput: out_ready=1, in_valid=1 for 16 cycles -> 16 outputs on consecutive cycles, with in_ready never low.
- Reset mid-flight: assert rst asynchronously, between clock edges, with 2 transfers in flight.
  - out_valid and busy drop before the next edge.
  - After release, no stale transfer emerges and the next input returns its correct result.
